// File: rtl/add_accum_mc.sv
// add_accum_mc
// ------------
// Adds two unsigned WIDTH-bit operands and can accumulate the result into one
// of CHANNELS per-channel accumulators, using wrap or saturating arithmetic.
// Every result is registered together with its channel tag and an overflow
// flag. Per-channel sticky overflow bits record any overflow since the last
// clear of that channel.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   input beat present
//   in_ready   block can accept a beat this cycle (combinational)
//   in_a/in_b  unsigned operands
//   in_ch      target channel; values >= CHANNELS map to channel 0
//   in_mode    00 ADD, 01 ACC (wrap), 10 SACC (saturate), 11 CLR (read-and-clear)
//   out_valid  registered result present
//   out_ready  consumer takes the result this cycle
//   out_sum    result
//   out_ch     channel of the result (0 when the request was remapped)
//   out_ovf    overflow / saturation for this result
//   ovf_sticky per-channel sticky overflow
module add_accum_mc #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CH_W     = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    input  logic [CH_W-1:0]     in_ch,
    input  logic [1:0]          in_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_sum,
    output logic [CH_W-1:0]     out_ch,
    output logic                out_ovf,
    output logic [CHANNELS-1:0] ovf_sticky
);

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_ACC  = 2'b01,
        MODE_SACC = 2'b10,
        MODE_CLR  = 2'b11
    } mode_e;

    // Two guard bits: acc + a + b never exceeds 3*MAX, which fits in WIDTH+2.
    localparam int              SW      = WIDTH + 2;
    localparam logic [SW-1:0]   MAX_S   = {2'b00, {WIDTH{1'b1}}};
    localparam logic [CH_W:0]   NUM_CH  = CHANNELS[CH_W:0];

    // Accumulators live in flops: CLR and back-to-back beats need a same-cycle
    // read of the addressed channel, which a registered-read RAM cannot give.
    logic [WIDTH-1:0]    acc_q [CHANNELS];
    logic [CHANNELS-1:0] sticky_q;

    logic                out_valid_q;
    logic [WIDTH-1:0]    out_sum_q,  out_sum_d;
    logic [CH_W-1:0]     out_ch_q;
    logic                out_ovf_q,  out_ovf_d;

    mode_e               mode;
    logic                accept;
    logic [CH_W-1:0]     eff_ch;
    logic [WIDTH-1:0]    acc_cur;
    logic [SW-1:0]       sum_s;
    logic                ovf;
    logic [WIDTH-1:0]    sat_val;
    logic [WIDTH-1:0]    acc_wr_d;
    logic                sticky_wr_d;

    assign mode     = mode_e'(in_mode);
    assign in_ready = !rst && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Out-of-range channel requests are folded onto channel 0.
    assign eff_ch   = ({1'b0, in_ch} < NUM_CH) ? in_ch : '0;
    assign acc_cur  = acc_q[eff_ch];

    assign sum_s    = SW'(in_a) + SW'(in_b)
                    + ((mode == MODE_ADD) ? '0 : SW'(acc_cur));
    assign ovf      = (sum_s > MAX_S);
    assign sat_val  = ovf ? {WIDTH{1'b1}} : sum_s[WIDTH-1:0];

    always_comb begin
        out_sum_d   = sum_s[WIDTH-1:0];
        out_ovf_d   = ovf;
        acc_wr_d    = acc_cur;
        sticky_wr_d = sticky_q[eff_ch];
        unique case (mode)
            MODE_ADD: begin
                out_sum_d = sum_s[WIDTH-1:0];
            end
            MODE_ACC: begin
                acc_wr_d    = sum_s[WIDTH-1:0];
                sticky_wr_d = sticky_q[eff_ch] | ovf;
            end
            MODE_SACC: begin
                out_sum_d   = sat_val;
                acc_wr_d    = sat_val;
                sticky_wr_d = sticky_q[eff_ch] | ovf;
            end
            MODE_CLR: begin
                out_sum_d   = acc_cur;
                out_ovf_d   = 1'b0;
                acc_wr_d    = '0;
                sticky_wr_d = 1'b0;
            end
            default: begin
                out_sum_d = sum_s[WIDTH-1:0];
            end
        endcase
    end

    // Per-channel state: only the addressed channel is written, and only on
    // an accepted non-ADD beat.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_q[gi]    <= '0;
                    sticky_q[gi] <= 1'b0;
                end else if (accept && (mode != MODE_ADD) && (eff_ch == CH_W'(gi))) begin
                    acc_q[gi]    <= acc_wr_d;
                    sticky_q[gi] <= sticky_wr_d;
                end
            end
        end
    endgenerate

    // Output register: loads on accept, drains on out_ready, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ch_q    <= '0;
            out_ovf_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_sum_q   <= out_sum_d;
            out_ch_q    <= eff_ch;
            out_ovf_q   <= out_ovf_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sum    = out_sum_q;
    assign out_ch     = out_ch_q;
    assign out_ovf    = out_ovf_q;
    assign ovf_sticky = sticky_q;

endmodule
